// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the LVDS receive lane trainer.
//   - state_t      : trainer FSM encoding
//   - DW_DEF       : default parallel word width (1:7 deserialiser)
//   - DLY_W_DEF    : default IDELAY code width
//   - ALIGN_PAT_DEF: nominal clock-lane word
//   - rotl()       : word rotation used for both the align search and the data path
package lvds_rx_pkg;

    localparam int DW_DEF    = 7;
    localparam int DLY_W_DEF = 8;
    localparam logic [DW_DEF-1:0] ALIGN_PAT_DEF = 7'b1100011;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET,
        ST_SETTLE,
        ST_SAMPLE,
        ST_NEXT,
        ST_CENTER,
        ST_ALIGN,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    // Result bit i takes w[(i + r) mod DW]: the bit received r positions later
    // becomes bit 0, which is how the serial stream is re-framed.
    function automatic logic [DW_DEF-1:0] rotl(input logic [DW_DEF-1:0] w,
                                               input logic [2:0]        r);
        logic [2*DW_DEF-1:0] t;
        t = {w, w} >> r;
        return t[DW_DEF-1:0];
    endfunction

endpackage

// File: rtl/lvds_eye_tracker.sv
// Per-lane eye tracker. Tracks whether the P and N sample paths agreed for a
// whole sample window, and keeps the current and the widest run of stable
// delay codes seen during the sweep.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : drop all run history (new training)
//   arm_i        : set the stable flag ahead of a sample window
//   sample_i     : sample window active; any P/N difference clears stable
//   update_i     : close the window for code_i and update the run trackers
//   pdata_i/ndata_i : this lane's P and N words
//   center_o     : centre code of the widest run
//   eye_ok_o     : widest run is at least MIN_EYE codes
module lvds_eye_tracker
    import lvds_rx_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DLY_W   = DLY_W_DEF,
    parameter int MIN_EYE = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             arm_i,
    input  logic             sample_i,
    input  logic             update_i,
    input  logic [DLY_W-1:0] code_i,
    input  logic [DW-1:0]    pdata_i,
    input  logic [DW-1:0]    ndata_i,
    output logic [DLY_W-1:0] center_o,
    output logic             eye_ok_o
);

    logic             stable_q, stable_d;
    logic [DLY_W-1:0] cur_start_q, cur_start_d;
    logic [DLY_W-1:0] best_start_q, best_start_d;
    // One extra bit so a run covering every code cannot overflow.
    logic [DLY_W:0]   cur_len_q, cur_len_d;
    logic [DLY_W:0]   best_len_q, best_len_d;

    always_comb begin
        stable_d     = stable_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (clear_i) begin
            stable_d     = 1'b1;
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else begin
            if (arm_i) begin
                stable_d = 1'b1;
            end else if (sample_i && (pdata_i != ndata_i)) begin
                stable_d = 1'b0;
            end
            if (update_i) begin
                if (stable_q) begin
                    if (cur_len_q == '0) begin
                        cur_start_d = code_i;
                    end
                    cur_len_d = cur_len_q + 1'b1;
                    // Strict compare: the earliest of equally wide eyes wins.
                    if (cur_len_d > best_len_q) begin
                        best_start_d = cur_start_d;
                        best_len_d   = cur_len_d;
                    end
                end else begin
                    cur_len_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q     <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            stable_q     <= stable_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign center_o = DLY_W'({1'b0, best_start_q} + ((best_len_q - 1'b1) >> 1));
    assign eye_ok_o = (best_len_q >= (DLY_W+1)'(MIN_EYE));

endmodule

// File: rtl/lvds_rx_lane_trainer.sv
// LVDS 1:7 receive lane trainer (pixel-clock domain).
// Sweeps a shared IDELAY code, finds each lane's widest P/N-stable eye,
// centres every lane in its eye, then searches the word rotation that
// frames the clock lane (lane 0) onto ALIGN_PAT and tracks lock.
//   I_clk_1x       : pixel clock
//   I_rst          : synchronous active-high reset
//   I_train_start  : pulse, (re)starts training from code 0
//   I_diff_pdata   : P-path words, lane i at [i*DW +: DW]
//   I_diff_ndata   : N-path words, same packing
//   O_idelay_num   : per-lane delay code
//   O_data         : rotated lane data, zero unless locked
//   O_rot          : selected rotation
//   O_busy         : sweep / centre / align in progress
//   O_locked       : aligned and tracking
//   O_fail         : sticky failure flag
module lvds_rx_lane_trainer
    import lvds_rx_pkg::*;
#(
    parameter int              LANES     = 4,
    parameter int              DW        = DW_DEF,
    parameter int              DLY_W     = DLY_W_DEF,
    parameter int              DLY_MAX   = 253,
    parameter int              SETTLE    = 16,
    parameter int              SAMPLE    = 64,
    parameter int              MIN_EYE   = 8,
    parameter logic [DW-1:0]   ALIGN_PAT = ALIGN_PAT_DEF,
    parameter int              LOSS_LIM  = 4
) (
    input  logic                   I_clk_1x,
    input  logic                   I_rst,
    input  logic                   I_train_start,
    input  logic [LANES*DW-1:0]    I_diff_pdata,
    input  logic [LANES*DW-1:0]    I_diff_ndata,
    output logic [LANES*DLY_W-1:0] O_idelay_num,
    output logic [LANES*DW-1:0]    O_data,
    output logic [2:0]             O_rot,
    output logic                   O_busy,
    output logic                   O_locked,
    output logic                   O_fail
);

    localparam int CNT_W = 16;

    state_t                 state_q, state_d;
    logic [DLY_W-1:0]       code_q, code_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             cand_q, cand_d;
    logic [2:0]             rot_q, rot_d;
    logic [2:0]             pass_q, pass_d;
    logic [7:0]             loss_q, loss_d;
    logic                   fail_q, fail_d;
    logic [LANES*DLY_W-1:0] dly_q, dly_d;
    logic [LANES*DW-1:0]    data_q;
    logic [LANES*DW-1:0]    rot_data_w;
    logic [LANES*DLY_W-1:0] center_w;
    logic [LANES-1:0]       eye_ok_w;
    logic                   match_cand_w;
    logic                   match_lock_w;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lvds_eye_tracker #(
            .DW      (DW),
            .DLY_W   (DLY_W),
            .MIN_EYE (MIN_EYE)
        ) u_eye (
            .clk_i    (I_clk_1x),
            .rst_i    (I_rst),
            .clear_i  (I_train_start),
            .arm_i    (state_q == ST_SET),
            .sample_i (state_q == ST_SAMPLE),
            .update_i (state_q == ST_NEXT),
            .code_i   (code_q),
            .pdata_i  (I_diff_pdata[g*DW +: DW]),
            .ndata_i  (I_diff_ndata[g*DW +: DW]),
            .center_o (center_w[g*DLY_W +: DLY_W]),
            .eye_ok_o (eye_ok_w[g])
        );
        // Rotating with rot_d lets the first LOCKED cycle already carry framed data.
        assign rot_data_w[g*DW +: DW] = rotl(I_diff_pdata[g*DW +: DW], rot_d);
    end

    assign match_cand_w = (rotl(I_diff_pdata[DW-1:0], cand_q) == ALIGN_PAT);
    assign match_lock_w = (rotl(I_diff_pdata[DW-1:0], rot_q) == ALIGN_PAT);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        rot_d   = rot_q;
        pass_d  = pass_q;
        loss_d  = loss_q;
        fail_d  = fail_q;
        dly_d   = dly_q;
        if (I_train_start) begin
            state_d = ST_SET;
            code_d  = '0;
            cnt_d   = '0;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_SET: begin
                    dly_d   = {LANES{code_q}};
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE-1)) begin
                        cnt_d   = '0;
                        state_d = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt_q == CNT_W'(SAMPLE-1)) begin
                        cnt_d   = '0;
                        state_d = ST_NEXT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (code_q == DLY_W'(DLY_MAX)) begin
                        cnt_d   = '0;
                        state_d = ST_CENTER;
                    end else begin
                        code_d  = code_q + 1'b1;
                        state_d = ST_SET;
                    end
                end
                ST_CENTER: begin
                    // cnt 0 loads the centred codes; cnt 1..SETTLE lets them settle.
                    if (cnt_q == '0) begin
                        dly_d = center_w;
                        if (!(&eye_ok_w)) begin
                            fail_d  = 1'b1;
                            state_d = ST_FAIL;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (cnt_q == CNT_W'(SETTLE)) begin
                        cand_d  = '0;
                        pass_d  = '0;
                        state_d = ST_ALIGN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_ALIGN: begin
                    if (match_cand_w) begin
                        rot_d   = cand_q;
                        loss_d  = '0;
                        state_d = ST_LOCKED;
                    end else if (cand_q == 3'(DW-1)) begin
                        cand_d = '0;
                        if (pass_q == 3'd3) begin
                            fail_d  = 1'b1;
                            state_d = ST_FAIL;
                        end else begin
                            pass_d = pass_q + 1'b1;
                        end
                    end else begin
                        cand_d = cand_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (match_lock_w) begin
                        loss_d = '0;
                    end else if (loss_q == 8'(LOSS_LIM-1)) begin
                        // Re-align with the current delay codes.
                        loss_d  = '0;
                        cand_d  = '0;
                        pass_d  = '0;
                        state_d = ST_ALIGN;
                    end else begin
                        loss_d = loss_q + 1'b1;
                    end
                end
                ST_FAIL: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_clk_1x) begin
        if (I_rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            cnt_q   <= '0;
            cand_q  <= '0;
            rot_q   <= '0;
            pass_q  <= '0;
            loss_q  <= '0;
            fail_q  <= 1'b0;
            dly_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            rot_q   <= rot_d;
            pass_q  <= pass_d;
            loss_q  <= loss_d;
            fail_q  <= fail_d;
            dly_q   <= dly_d;
            data_q  <= rot_data_w;
        end
    end

    assign O_idelay_num = dly_q;
    assign O_data       = (state_q == ST_LOCKED) ? data_q : '0;
    assign O_rot        = rot_q;
    assign O_busy       = (state_q == ST_SET)    || (state_q == ST_SETTLE) ||
                          (state_q == ST_SAMPLE) || (state_q == ST_NEXT)   ||
                          (state_q == ST_CENTER) || (state_q == ST_ALIGN);
    assign O_locked     = (state_q == ST_LOCKED);
    assign O_fail       = fail_q;

endmodule

// File: tb/tb_lvds_rx_lane_trainer.sv
module tb_lvds_rx_lane_trainer;
    import lvds_rx_pkg::*;

    localparam int LANES    = 2;
    localparam int DW       = 7;
    localparam int DLY_W    = 8;
    localparam int DLY_MAX  = 31;
    localparam int SETTLE   = 2;
    localparam int SAMPLE   = 4;
    localparam int MIN_EYE  = 4;
    localparam int LOSS_LIM = 4;
    localparam logic [DW-1:0] PAT = 7'b1100011;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [LANES*DW-1:0]    pdata;
    logic [LANES*DW-1:0]    ndata;
    logic [LANES*DLY_W-1:0] idelay;
    logic [LANES*DW-1:0]    odata;
    logic [2:0]             orot;
    logic                   busy, locked, fail;

    lvds_rx_lane_trainer #(
        .LANES(LANES), .DW(DW), .DLY_W(DLY_W), .DLY_MAX(DLY_MAX),
        .SETTLE(SETTLE), .SAMPLE(SAMPLE), .MIN_EYE(MIN_EYE),
        .ALIGN_PAT(PAT), .LOSS_LIM(LOSS_LIM)
    ) dut (
        .I_clk_1x(clk), .I_rst(rst), .I_train_start(start),
        .I_diff_pdata(pdata), .I_diff_ndata(ndata),
        .O_idelay_num(idelay), .O_data(odata), .O_rot(orot),
        .O_busy(busy), .O_locked(locked), .O_fail(fail)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;

    // Lane environment: which delay codes give matching P/N samples.
    bit            eye [LANES][256];
    logic [DW-1:0] clk_word;
    int            corrupt;
    logic [DW-1:0] prev_p1;

    typedef struct {
        int            l0a_lo, l0a_hi, l0b_lo, l0b_hi, l1_lo, l1_hi;
        logic [DW-1:0] word;
        bit            exp_fail;
        int            exp_c0, exp_c1, exp_rot;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rotl(input logic [DW-1:0] w, input int r);
        logic [DW-1:0] res;
        for (int i = 0; i < DW; i++) res[i] = w[(i + r) % DW];
        return res;
    endfunction

    function automatic int model_rot(input logic [DW-1:0] w);
        for (int r = 0; r < DW; r++) if (model_rotl(w, r) == PAT) return r;
        return -1;
    endfunction

    // Widest run of stable codes (earliest on ties) and its centre.
    task automatic model_eye(input int lane, output int centre, output int len);
        int best_s = 0, best_l = 0, run = 0;
        for (int c = 0; c <= DLY_MAX; c++) begin
            run = eye[lane][c] ? run + 1 : 0;
            if (run > best_l) begin
                best_l = run;
                best_s = c - run + 1;
            end
        end
        len    = best_l;
        centre = best_s + (best_l - 1) / 2;
    endtask

    task automatic clear_eyes();
        for (int l = 0; l < LANES; l++)
            for (int c = 0; c < 256; c++) eye[l][c] = 1'b0;
    endtask

    task automatic set_eye(input int lane, input int lo, input int hi);
        if (lo < 0) return;
        for (int c = lo; c <= hi && c <= DLY_MAX; c++) eye[lane][c] = 1'b1;
    endtask

    task automatic drive();
        logic [DW-1:0] w;
        int c;
        prev_p1 = pdata[DW +: DW];
        for (int l = 0; l < LANES; l++) begin
            if (l == 0) begin
                w = clk_word;
                if (corrupt > 0) begin
                    w = w ^ 7'h01;
                    corrupt--;
                end
            end else begin
                w = DW'($urandom);
            end
            c = int'(idelay[l*DLY_W +: DLY_W]);
            pdata[l*DW +: DW] = w;
            ndata[l*DW +: DW] = eye[l][c] ? w : (w ^ 7'h55);
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive();
    endtask

    task automatic train(output bit timeout, output int lat);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        timeout = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            lat++;
            if (locked || fail) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_case(input string tag, input bit exp_fail,
                            input int exp_c0, input int exp_c1, input int exp_rot);
        bit to;
        int lat;
        int sweep;
        sweep = (DLY_MAX + 1) * (SETTLE + SAMPLE + 2);
        train(to, lat);
        chk({tag, " timeout"}, to, 0);
        if (to) return;
        chk({tag, " fail"}, fail, exp_fail);
        chk({tag, " locked"}, locked, !exp_fail);
        chk({tag, " busy"}, busy, 0);
        if (!exp_fail) begin
            chk({tag, " latency"}, lat, 1 + sweep + 1 + SETTLE + exp_rot + 1);
            chk({tag, " code0"}, idelay[0 +: DLY_W], exp_c0);
            chk({tag, " code1"}, idelay[DLY_W +: DLY_W], exp_c1);
            chk({tag, " rot"}, orot, exp_rot);
            for (int k = 0; k < 5; k++) begin
                step();
                chk({tag, " data0"}, odata[0 +: DW], PAT);
                chk({tag, " data1"}, odata[DW +: DW], model_rotl(prev_p1, exp_rot));
            end
            chk({tag, " hold0"}, idelay[0 +: DLY_W], exp_c0);
            chk({tag, " hold1"}, idelay[DLY_W +: DLY_W], exp_c1);
        end else begin
            chk({tag, " fail latency"}, lat, 2 + sweep);
            chk({tag, " data zero"}, odata, 0);
            repeat (5) step();
            chk({tag, " fail sticky"}, fail, 1);
            chk({tag, " fail unlocked"}, locked, 0);
        end
    endtask

    initial begin
        bit to;
        int c0, c1, len0, len1, lo, k, relock_wait;
        logic [DW-1:0] w;

        vecs[0] = '{8, 19, -1, -1, 3, 10, 7'b0011110, 1'b0, 13, 6, 3};
        vecs[1] = '{8, 19, -1, -1, 3,  5, 7'b0011110, 1'b1,  0, 0, 0};
        vecs[2] = '{2,  6, 20, 29, 3, 10, 7'b0011110, 1'b0, 24, 6, 3};
        vecs[3] = '{25, 31, -1, -1, 3, 10, 7'b0011110, 1'b0, 28, 6, 3};

        rst = 1'b1;
        start = 1'b0;
        pdata = '0;
        ndata = '0;
        corrupt = 0;
        clk_word = 7'b0011110;
        clear_eyes();
        repeat (3) step();
        chk("reset idelay", idelay, 0);
        chk("reset data", odata, 0);
        chk("reset rot", orot, 0);
        chk("reset flags", {busy, locked, fail}, 0);
        chk("reset state", dut.state_q, ST_IDLE);
        rst = 1'b0;
        step();
        chk("idle state", dut.state_q, ST_IDLE);

        for (int v = 0; v < 4; v++) begin
            clear_eyes();
            set_eye(0, vecs[v].l0a_lo, vecs[v].l0a_hi);
            set_eye(0, vecs[v].l0b_lo, vecs[v].l0b_hi);
            set_eye(1, vecs[v].l1_lo, vecs[v].l1_hi);
            clk_word = vecs[v].word;
            run_case($sformatf("vec%0d", v), vecs[v].exp_fail,
                     vecs[v].exp_c0, vecs[v].exp_c1, vecs[v].exp_rot);
            if (v == 0 && locked) begin
                corrupt = 3;
                repeat (4) step();
                chk("loss3 locked", locked, 1);
                step();
                corrupt = 4;
                repeat (5) step();
                chk("loss4 unlocked", locked, 0);
                chk("loss4 busy", busy, 1);
                chk("loss4 data zero", odata, 0);
                relock_wait = 0;
                while (!locked && relock_wait < 60) begin
                    step();
                    relock_wait++;
                end
                chk("relock", locked, 1);
                chk("relock rot", orot, 3);
                chk("relock code0", idelay[0 +: DLY_W], 13);
                chk("relock code1", idelay[DLY_W +: DLY_W], 6);
            end
            if (v == 1) begin
                start = 1'b1;
                step();
                start = 1'b0;
                chk("start clears fail", fail, 0);
                chk("start sets busy", busy, 1);
            end
        end

        for (int n = 0; n < 4; n++) begin
            clear_eyes();
            for (int l = 0; l < LANES; l++) begin
                lo = $urandom_range(0, 24);
                set_eye(l, lo, lo + $urandom_range(1, 11));
                lo = $urandom_range(0, 28);
                set_eye(l, lo, lo + $urandom_range(0, 4));
            end
            k = $urandom_range(0, DW - 1);
            clk_word = model_rotl(PAT, k);
            model_eye(0, c0, len0);
            model_eye(1, c1, len1);
            run_case($sformatf("rand%0d", n), (len0 < MIN_EYE) || (len1 < MIN_EYE),
                     c0, c1, model_rot(clk_word));
        end

        // Reset in the middle of a sweep.
        clear_eyes();
        set_eye(0, 8, 19);
        set_eye(1, 3, 10);
        clk_word = 7'b0011110;
        start = 1'b1;
        step();
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (idelay[0 +: DLY_W] == 8'd17) begin
                to = 1'b0;
                break;
            end
        end
        chk("reach code17", to, 0);
        repeat (2) step();
        chk("in sample", dut.state_q, ST_SAMPLE);
        rst = 1'b1;
        step();
        chk("midrst idelay", idelay, 0);
        chk("midrst data", odata, 0);
        chk("midrst rot", orot, 0);
        chk("midrst flags", {busy, locked, fail}, 0);
        chk("midrst state", dut.state_q, ST_IDLE);
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("restart code0", idelay[0 +: DLY_W], 0);
        chk("restart busy", busy, 1);
        step();
        chk("restart code1", idelay[0 +: DLY_W], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lvds_rx_lane_trainer.md
# lvds_rx_lane_trainer

Multi-lane training controller for the 1:7 LVDS receive path, running in the pixel-clock domain behind the per-lane deserializers. It sweeps the shared IDELAY code and uses the P/N sample pairs (N path delayed by a fixed offset) to find each lane's widest stable eye. It then centres each lane's delay and finds the word rotation that aligns the clock lane to its nominal pattern. While locked, it outputs rotated, aligned parallel data for every lane.

## Interface
- LANES, 4, number of lanes; lane 0 is the LVDS clock lane
- DW, 7, bits per parallel word
- DLY_W, 8, IDELAY code width
- DLY_MAX, 253, highest swept code; leaves headroom for the external +2 N-path offset
- SETTLE, 16, cycles to wait after each code change
- SAMPLE, 64, compare cycles per code
- MIN_EYE, 8, minimum stable codes per lane
- ALIGN_PAT, 7'b1100011, expected clock-lane word
- LOSS_LIM, 4, consecutive clock-lane mismatches that drop lock
- I_clk_1x  in  1  pixel clock; the only clock
- I_rst  in  1  synchronous, active-high reset
- I_train_start  in  1  one-cycle pulse; starts or restarts training
- I_diff_pdata  in  LANES*DW  P-path words, lane i at [i*DW +: DW]
- I_diff_ndata  in  LANES*DW  N-path words, same packing
- O_idelay_num  out  LANES*DLY_W  per-lane delay code
- O_data  out  LANES*DW  aligned data
- O_rot  out  3  selected rotation, 0..DW-1
- O_busy  out  1  training in progress
- O_locked  out  1  aligned and tracking
- O_fail  out  1  sticky until next I_train_start or reset

## Operation
- States: IDLE, SET, SETTLE, SAMPLE, NEXT, CENTER, ALIGN, LOCKED, FAIL.
- IDLE: I_train_start -> SET with code=0. All per-lane run trackers are cleared and O_fail is cleared.
- SET (1 cycle): every lane's O_idelay_num is driven to the sweep code. Then SETTLE.
- SETTLE (SETTLE cycles). Then SAMPLE.
- SAMPLE (SAMPLE cycles): a lane's stable flag starts at 1 and is cleared on any cycle where pdata_i != ndata_i.
- NEXT (1 cycle): per-lane run update.
  - If stable: when cur_len==0, set cur_start=code. Then cur_len+1; if the new cur_len > best_len, set best_start=cur_start and best_len=cur_len.
  - If not stable: cur_len=0.
  - If code==DLY_MAX go to CENTER; otherwise code+1 and go to SET.
- CENTER (1 cycle): lane code = best_start + ((best_len-1)>>1). Arithmetic is DLY_W+1 bits wide, truncated to DLY_W.
  - If any best_len < MIN_EYE -> FAIL. Otherwise wait SETTLE cycles, then ALIGN with r=0.
- ALIGN: one candidate per cycle. Match when rotl(lane0 pdata, r)==ALIGN_PAT.
  - On match: latch O_rot=r and go to LOCKED.
  - After r=DW-1 without a match, restart at r=0. After 4 full passes without a match -> FAIL.
- LOCKED: O_data lane i = rotl(pdata_i, O_rot). Clock-lane mismatches are counted.
  - LOSS_LIM consecutive mismatches -> ALIGN with r=0 (delay codes are kept); O_locked drops.
  - Any match clears the counter.
- FAIL: O_fail=1 and the delay codes are held. Only I_train_start leaves FAIL.
- I_train_start in any state restarts training from SET with code=0 (IDLE clear actions apply).
- A run still open at DLY_MAX is already counted in best; no wrap-around to code 0.

## Timing
- Reset values: state IDLE; O_idelay_num all 0; O_data 0; O_rot 0; O_busy 0; O_locked 0; O_fail 0.
- O_busy=1 in SET through ALIGN.
- Per-code dwell is exactly 1+SETTLE+SAMPLE+1 cycles.
- Full sweep takes (DLY_MAX+1)*(SETTLE+SAMPLE+2) cycles.
- O_data has 1-cycle latency from I_diff_pdata (registered). O_data is forced to 0 when not LOCKED.
- O_locked rises in the cycle after the matching ALIGN cycle.
- O_idelay_num is registered and changes only in SET and CENTER.
- Reset mid-sweep returns every output to its reset value on the next edge.

## Structure
- Shared package lvds_rx_pkg holds the state encoding, ALIGN_PAT default, the DLY_W/DW defaults and the rotl function.
- One sub-module, lvds_eye_tracker, is instantiated LANES times. It holds the stable flag and cur/best start and length, and outputs the centre code and an eye_ok flag.
- The FSM, sweep counter, align search and lock monitor live in the top level.

## Test plan
- LANES=2, DLY_MAX=31, SETTLE=2, SAMPLE=4, MIN_EYE=4. Model p==n for lane0 at codes 8..19 and lane1 at 3..10 -> lane codes 13 and 6; each lane holds that code.
- Clock lane presents 7'b0011110 (rotl by 3 = 1100011) -> O_rot=3 and O_locked=1. O_data lane1 = rotl(pdata1, 3) one cycle later.
- Lane1 eye limited to codes 3..5 -> O_fail=1 and O_locked=0. I_train_start pulse clears O_fail.
- Two eyes on lane0, 2..6 and 20..29 -> centre 24. Eye 25..31, touching DLY_MAX -> centre 28.
- In LOCKED, corrupt the clock-lane word for 3 cycles -> still locked. Corrupt it for 4 cycles -> O_locked falls and re-align runs.
- Assert I_rst during SAMPLE at code 17 -> next edge shows all outputs zero and state IDLE. A new start resumes from code 0.
